// File: rtl/regfile_write_scheduler_pkg.sv
// Shared defaults and FSM state type for the register-file write scheduler.
package regfile_sched_pkg;
   localparam int DEF_DATA_W = 8;
   localparam int DEF_ADDR_W = 3;
   localparam int NREGS      = 1 << DEF_ADDR_W;

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } sched_state_e;
endpackage

// File: rtl/regfile_write_scheduler_if.sv
// Requester, register-file write port and hazard-query signals of the write scheduler.
interface regfile_write_scheduler_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 3
);
   logic              a_valid;
   logic [ADDR_W-1:0] a_addr;
   logic [DATA_W-1:0] a_data;
   logic              a_ready;
   logic              b_valid;
   logic [ADDR_W-1:0] b_addr;
   logic [DATA_W-1:0] b_data;
   logic              b_ready;
   logic              hold;
   logic              rf_we;
   logic [ADDR_W-1:0] rf_waddr;
   logic [DATA_W-1:0] rf_wdata;
   logic [ADDR_W-1:0] rd_addr;
   logic              rd_pending;
   logic              init_done;

   modport master (
      output a_valid, a_addr, a_data, b_valid, b_addr, b_data, hold, rd_addr,
      input  a_ready, b_ready, rf_we, rf_waddr, rf_wdata, rd_pending, init_done
   );

   modport slave (
      input  a_valid, a_addr, a_data, b_valid, b_addr, b_data, hold, rd_addr,
      output a_ready, b_ready, rf_we, rf_waddr, rf_wdata, rd_pending, init_done
   );
endinterface

// File: rtl/regfile_write_scheduler_arbiter.sv
// Two-requester round-robin arbiter; pointer 0 favours req[0] (requester A).
module rr_arbiter2 (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] gnt
);
   logic ptr_q;

   always_comb begin
      gnt = req;
      if (req == 2'b11) gnt = ptr_q ? 2'b10 : 2'b01;
   end

   // After any grant the pointer favours the requester that was not served.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                         ptr_q <= 1'b0;
      else if (advance && (gnt != 2'b00)) ptr_q <= gnt[0];
   end
endmodule

// File: rtl/regfile_write_scheduler.sv
// Arbitrates ALU and load writebacks onto one registered register-file write port.
// Define REGFILE_SCHED_INIT_EN to zero every register with an INIT sweep after reset.
module regfile_write_scheduler
   import regfile_sched_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input logic                      clk,
   input logic                      reset,
   regfile_write_scheduler_if.slave bus
);
   sched_state_e      state_q, state_d;
   logic              grant_en;
   logic              init_done_c;
   logic [1:0]        req, gnt;
   logic              we_p1;
   logic [ADDR_W-1:0] waddr_p1;
   logic [DATA_W-1:0] wdata_p1;
`ifdef REGFILE_SCHED_INIT_EN
   logic [ADDR_W-1:0] cnt_q;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= INIT;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d     = state_q;
      grant_en    = 1'b0;
      init_done_c = 1'b0;
      case (state_q)
         INIT: begin
`ifdef REGFILE_SCHED_INIT_EN
            if (cnt_q == {ADDR_W{1'b1}}) state_d = RUN;
`else
            state_d = RUN;
`endif
         end
         RUN: begin
            grant_en    = !bus.hold;
            init_done_c = 1'b1;
         end
         default: state_d = INIT;
      endcase
   end

`ifdef REGFILE_SCHED_INIT_EN
   // Wraps from all-ones on the same edge that leaves INIT.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)               cnt_q <= '0;
      else if (state_q == INIT) cnt_q <= cnt_q + 1'b1;
   end
`endif

   assign req = {bus.b_valid, bus.a_valid} & {2{grant_en}};

   rr_arbiter2 u_arb (
      .clk    (clk),
      .reset  (reset),
      .req    (req),
      .advance(grant_en),
      .gnt    (gnt)
   );

   // Stage p1: accepted write (or init sweep) registered onto the write port.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         we_p1    <= 1'b0;
         waddr_p1 <= '0;
         wdata_p1 <= '0;
      end else if (state_q == INIT) begin
`ifdef REGFILE_SCHED_INIT_EN
         we_p1    <= 1'b1;
         waddr_p1 <= cnt_q;
         wdata_p1 <= '0;
`else
         we_p1    <= 1'b0;
`endif
      end else if (gnt[0]) begin
         we_p1    <= (bus.a_addr != '0);
         waddr_p1 <= bus.a_addr;
         wdata_p1 <= bus.a_data;
      end else if (gnt[1]) begin
         we_p1    <= (bus.b_addr != '0);
         waddr_p1 <= bus.b_addr;
         wdata_p1 <= bus.b_data;
      end else begin
         we_p1    <= 1'b0;
      end
   end

   assign bus.a_ready   = gnt[0];
   assign bus.b_ready   = gnt[1];
   assign bus.rf_we     = we_p1;
   assign bus.rf_waddr  = waddr_p1;
   assign bus.rf_wdata  = wdata_p1;
   assign bus.init_done = init_done_c;

   // Register 0 never hazards: it is hardwired zero.
   assign bus.rd_pending = (bus.rd_addr != '0) &&
                           ((bus.a_valid && (bus.a_addr == bus.rd_addr)) ||
                            (bus.b_valid && (bus.b_addr == bus.rd_addr)) ||
                            (we_p1 && (waddr_p1 == bus.rd_addr)));
endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Directed bench for regfile_write_scheduler; covers both REGFILE_SCHED_INIT_EN builds.
module tb_regfile_write_scheduler;
   logic clk;
   logic reset;
   int   errors;
   int   checks;

   regfile_write_scheduler_if #(.DATA_W(8), .ADDR_W(3)) bus ();

   regfile_write_scheduler #(.DATA_W(8), .ADDR_W(3)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic run_init;
      bus.a_valid = 1'b1; bus.a_addr = 3'd2; bus.a_data = 8'hC3;
      #1;
      checks++; if (bus.init_done !== 1'b0) begin errors++; $display("FAIL init_pre_done: got %b want 0", bus.init_done); end
      checks++; if (bus.a_ready !== 1'b0) begin errors++; $display("FAIL init_pre_ready: got %b want 0", bus.a_ready); end
      checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL init_pre_we: got %b want 0", bus.rf_we); end
`ifdef REGFILE_SCHED_INIT_EN
      for (int i = 0; i < 8; i++) begin
         logic [2:0] exp_addr;
         exp_addr = i[2:0];
         tick();
         checks++; if (bus.rf_we !== 1'b1) begin errors++; $display("FAIL init_we[%0d]: got %b want 1", i, bus.rf_we); end
         checks++; if (bus.rf_waddr !== exp_addr) begin errors++; $display("FAIL init_waddr[%0d]: got %0d want %0d", i, bus.rf_waddr, exp_addr); end
         checks++; if (bus.rf_wdata !== 8'h00) begin errors++; $display("FAIL init_wdata[%0d]: got %h want 00", i, bus.rf_wdata); end
         if (i < 7) begin
            checks++; if (bus.init_done !== 1'b0) begin errors++; $display("FAIL init_done_early[%0d]: got %b want 0", i, bus.init_done); end
            checks++; if (bus.a_ready !== 1'b0) begin errors++; $display("FAIL init_grant[%0d]: got %b want 0", i, bus.a_ready); end
         end else begin
            checks++; if (bus.init_done !== 1'b1) begin errors++; $display("FAIL init_done_rise: got %b want 1", bus.init_done); end
         end
         if (i == 6) bus.a_valid = 1'b0;
      end
`else
      bus.a_valid = 1'b0;
      tick();
      checks++; if (bus.init_done !== 1'b1) begin errors++; $display("FAIL init_done_rise: got %b want 1", bus.init_done); end
      checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL init_we_off: got %b want 0", bus.rf_we); end
`endif
      tick();
      checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL init_no_extra: got %b want 0", bus.rf_we); end
      checks++; if (bus.init_done !== 1'b1) begin errors++; $display("FAIL init_done_hold: got %b want 1", bus.init_done); end
   endtask

   task automatic test_reset;
      reset = 1'b0;
      bus.a_valid = 1'b1; bus.a_addr = 3'd1; bus.a_data = 8'h11;
      bus.b_valid = 1'b1; bus.b_addr = 3'd2; bus.b_data = 8'h22;
      bus.hold = 1'b0; bus.rd_addr = 3'd0;
      tick(); tick();
      checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", bus.rf_we); end
      checks++; if (bus.rf_waddr !== 3'd0) begin errors++; $display("FAIL reset_waddr: got %0d want 0", bus.rf_waddr); end
      checks++; if (bus.rf_wdata !== 8'h00) begin errors++; $display("FAIL reset_wdata: got %h want 00", bus.rf_wdata); end
      checks++; if (bus.init_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.init_done); end
      checks++; if ({bus.a_ready, bus.b_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b want 00", {bus.a_ready, bus.b_ready}); end
      bus.b_valid = 1'b0;
      reset = 1'b1;
      run_init();
   endtask

   task automatic test_round_robin;
      bus.a_valid = 1'b1; bus.a_addr = 3'd1; bus.a_data = 8'h11;
      bus.b_valid = 1'b1; bus.b_addr = 3'd2; bus.b_data = 8'h22;
      for (int k = 0; k < 4; k++) begin
         logic [1:0] exp_gnt;
         logic [2:0] exp_addr;
         logic [7:0] exp_data;
         exp_gnt  = (k % 2 == 0) ? 2'b01 : 2'b10;
         exp_addr = (k % 2 == 0) ? 3'd1 : 3'd2;
         exp_data = (k % 2 == 0) ? 8'h11 : 8'h22;
         #1;
         checks++; if ({bus.b_ready, bus.a_ready} !== exp_gnt) begin errors++; $display("FAIL rr_grant[%0d]: got %b want %b", k, {bus.b_ready, bus.a_ready}, exp_gnt); end
         tick();
         if (k == 3) begin bus.a_valid = 1'b0; bus.b_valid = 1'b0; end
         checks++; if (bus.rf_we !== 1'b1) begin errors++; $display("FAIL rr_we[%0d]: got %b want 1", k, bus.rf_we); end
         checks++; if (bus.rf_waddr !== exp_addr) begin errors++; $display("FAIL rr_waddr[%0d]: got %0d want %0d", k, bus.rf_waddr, exp_addr); end
         checks++; if (bus.rf_wdata !== exp_data) begin errors++; $display("FAIL rr_wdata[%0d]: got %h want %h", k, bus.rf_wdata, exp_data); end
      end
      tick();
      checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL rr_idle_we: got %b want 0", bus.rf_we); end
   endtask

   task automatic test_single_a;
      bus.a_valid = 1'b1; bus.a_addr = 3'd3; bus.a_data = 8'h5A;
      #1;
      checks++; if ({bus.b_ready, bus.a_ready} !== 2'b01) begin errors++; $display("FAIL single_a_grant: got %b want 01", {bus.b_ready, bus.a_ready}); end
      tick();
      bus.a_valid = 1'b0;
      checks++; if (bus.rf_we !== 1'b1) begin errors++; $display("FAIL single_a_we: got %b want 1", bus.rf_we); end
      checks++; if (bus.rf_waddr !== 3'd3) begin errors++; $display("FAIL single_a_waddr: got %0d want 3", bus.rf_waddr); end
      checks++; if (bus.rf_wdata !== 8'h5A) begin errors++; $display("FAIL single_a_wdata: got %h want 5a", bus.rf_wdata); end
      tick();
      checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL single_a_one_cycle: got %b want 0", bus.rf_we); end
   endtask

   task automatic test_addr_zero;
      bus.b_valid = 1'b1; bus.b_addr = 3'd0; bus.b_data = 8'hFF; bus.rd_addr = 3'd0;
      #1;
      checks++; if ({bus.b_ready, bus.a_ready} !== 2'b10) begin errors++; $display("FAIL zero_grant: got %b want 10", {bus.b_ready, bus.a_ready}); end
      checks++; if (bus.rd_pending !== 1'b0) begin errors++; $display("FAIL zero_pending: got %b want 0", bus.rd_pending); end
      tick();
      bus.b_valid = 1'b0;
      checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL zero_we: got %b want 0", bus.rf_we); end
   endtask

   task automatic test_same_addr;
      bus.a_valid = 1'b1; bus.a_addr = 3'd4; bus.a_data = 8'hA1;
      bus.b_valid = 1'b1; bus.b_addr = 3'd4; bus.b_data = 8'hB2;
      #1;
      checks++; if ({bus.b_ready, bus.a_ready} !== 2'b01) begin errors++; $display("FAIL same_grant0: got %b want 01", {bus.b_ready, bus.a_ready}); end
      tick();
      bus.a_valid = 1'b0;
      checks++; if (bus.rf_wdata !== 8'hA1) begin errors++; $display("FAIL same_wdata0: got %h want a1", bus.rf_wdata); end
      #1;
      checks++; if ({bus.b_ready, bus.a_ready} !== 2'b10) begin errors++; $display("FAIL same_grant1: got %b want 10", {bus.b_ready, bus.a_ready}); end
      tick();
      bus.b_valid = 1'b0;
      checks++; if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata} !== {1'b1, 3'd4, 8'hB2}) begin errors++; $display("FAIL same_final: got we=%b addr=%0d data=%h want we=1 addr=4 data=b2", bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
      tick();
   endtask

   task automatic test_hold_hazard;
      bus.hold = 1'b1; bus.a_valid = 1'b1; bus.a_addr = 3'd5; bus.a_data = 8'h77; bus.rd_addr = 3'd5;
      #1;
      checks++; if (bus.a_ready !== 1'b0) begin errors++; $display("FAIL hold_ready: got %b want 0", bus.a_ready); end
      checks++; if (bus.rd_pending !== 1'b1) begin errors++; $display("FAIL hold_pending: got %b want 1", bus.rd_pending); end
      tick();
      checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL hold_we: got %b want 0", bus.rf_we); end
      bus.hold = 1'b0;
      #1;
      checks++; if (bus.a_ready !== 1'b1) begin errors++; $display("FAIL unhold_ready: got %b want 1", bus.a_ready); end
      tick();
      bus.a_valid = 1'b0;
      #1;
      checks++; if ({bus.rf_we, bus.rf_waddr} !== {1'b1, 3'd5}) begin errors++; $display("FAIL unhold_write: got we=%b addr=%0d want we=1 addr=5", bus.rf_we, bus.rf_waddr); end
      checks++; if (bus.rd_pending !== 1'b1) begin errors++; $display("FAIL inflight_pending: got %b want 1", bus.rd_pending); end
      tick();
      checks++; if (bus.rd_pending !== 1'b0) begin errors++; $display("FAIL after_pending: got %b want 0", bus.rd_pending); end
      bus.rd_addr = 3'd0;
   endtask

   task automatic test_reset_mid;
      bus.a_valid = 1'b1; bus.a_addr = 3'd6; bus.a_data = 8'h33;
      tick();
      bus.a_valid = 1'b0;
      #1;
      checks++; if (bus.rf_we !== 1'b1) begin errors++; $display("FAIL mid_inflight: got %b want 1", bus.rf_we); end
      reset = 1'b0;
      #1;
      checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL mid_we_clear: got %b want 0", bus.rf_we); end
      checks++; if (bus.init_done !== 1'b0) begin errors++; $display("FAIL mid_done_clear: got %b want 0", bus.init_done); end
      tick();
      reset = 1'b1;
      run_init();
   endtask

   initial begin
      errors = 0;
      checks = 0;
      test_reset();
      test_round_robin();
      test_single_a();
      test_addr_zero();
      test_same_addr();
      test_hold_hazard();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
